car_motion_model: RTL and testbench

- Closed-loop plant model; drives the sensor inputs of car_speed_control.
- Consumes accelerate_car and unlock_doors commands.
- Produces car_speed and leading_distance, so controller plus model form a synthesizable self-checking loop on one clock.
- Speed and gap update once per physics tick. A sample_valid strobe marks fresh sensor data.

---
 rtl/car_pkg.sv | 16 +
 rtl/tick_gen.sv | 26 ++
 rtl/car_motion_model.sv | 113 +++++++++++
 tb/tb_car_motion_model.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// Shared types and constants for the car controller / plant loop.
package car_pkg;

  localparam int SPEED_W = 8;
  localparam int DIST_W  = 7;

  localparam logic [DIST_W-1:0]  MIN_DISTANCE = 7'd40;
  localparam logic [SPEED_W-1:0] MAX_SPEED    = 8'd255;

  typedef enum logic [1:0] {
    PARKED = 2'd0,
    ACCEL  = 2'd1,
    DECEL  = 2'd2
  } car_state_e;

endpackage

// File: rtl/tick_gen.sv
// Physics tick generator: wrapping counter, tick on last count.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/car_motion_model.sv
// Closed-loop vehicle plant: own speed, gap to leader, safety flags.
module car_motion_model
  import car_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int ACCEL_STEP = 5,
  parameter int DECEL_STEP = 10,
  parameter int DIST_SHIFT = 3,
  parameter logic [DIST_W-1:0] INIT_DISTANCE = 7'd100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accelerate_car,
  input  logic               unlock_doors,
  input  logic [SPEED_W-1:0] leader_speed,
  output logic [SPEED_W-1:0] car_speed,
  output logic [DIST_W-1:0]  leading_distance,
  output logic               sample_valid,
  output logic               collision,
  output logic               door_fault
);

  car_state_e state;
  logic       tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [SPEED_W:0]   acc_sum;
  logic [SPEED_W-1:0] spd_up;
  logic [SPEED_W-1:0] spd_dn;
  logic [SPEED_W-1:0] spd_new;
  logic signed [8:0]  rel;
  logic signed [8:0]  delta;
  logic signed [9:0]  gap_sum;
  logic [DIST_W-1:0]  gap_new;
  logic               hit;

  assign acc_sum = {1'b0, car_speed} + 9'(ACCEL_STEP);
  assign spd_up  = acc_sum[SPEED_W] ? MAX_SPEED : acc_sum[SPEED_W-1:0];
  assign spd_dn  = (car_speed > SPEED_W'(DECEL_STEP))
                 ? car_speed - SPEED_W'(DECEL_STEP) : '0;

  // Gap moves by the relative speed, floored toward -inf by the shift.
  assign rel     = $signed({1'b0, leader_speed}) - $signed({1'b0, car_speed});
  assign delta   = rel >>> DIST_SHIFT;
  assign gap_sum = $signed({3'b000, leading_distance})
                 + $signed({delta[8], delta});

  always_comb begin
    gap_new = gap_sum[DIST_W-1:0];
    if (gap_sum < 10'sd0)
      gap_new = '0;
    else if (gap_sum > 10'sd127)
      gap_new = 7'd127;
  end

  always_comb begin
    spd_new = '0;
    unique case (state)
      ACCEL:   spd_new = spd_up;
      DECEL:   spd_new = spd_dn;
      default: spd_new = '0;
    endcase
  end

  assign hit = (gap_new == '0) && (car_speed != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= PARKED;
      car_speed        <= '0;
      leading_distance <= INIT_DISTANCE;
      sample_valid     <= 1'b0;
      collision        <= 1'b0;
      door_fault       <= 1'b0;
    end else begin
      sample_valid <= tick;
      if (unlock_doors && car_speed != '0)
        door_fault <= 1'b1;
      if (tick) begin
        car_speed        <= hit ? '0 : spd_new;
        leading_distance <= gap_new;
        if (hit)
          collision <= 1'b1;
      end
      // A crash pins the car in PARKED until reset.
      if (collision || (tick && hit)) begin
        state <= PARKED;
      end else begin
        unique case (state)
          PARKED:
            if (accelerate_car && !unlock_doors)
              state <= ACCEL;
          ACCEL:
            if (!accelerate_car)
              state <= DECEL;
          DECEL:
            if (tick && spd_new == '0)
              state <= PARKED;
            else if (accelerate_car)
              state <= ACCEL;
          default:
            state <= PARKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_car_motion_model.sv
// Bench for car_motion_model: vector table, crash sequence, random run.
module tb_car_motion_model;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       accelerate_car = 1'b0;
  logic       unlock_doors = 1'b0;
  logic [7:0] leader_speed = 8'd0;
  logic [7:0] car_speed;
  logic [6:0] leading_distance;
  logic       sample_valid;
  logic       collision;
  logic       door_fault;

  car_motion_model dut (
    .clk              (clk),
    .rst              (rst),
    .accelerate_car   (accelerate_car),
    .unlock_doors     (unlock_doors),
    .leader_speed     (leader_speed),
    .car_speed        (car_speed),
    .leading_distance (leading_distance),
    .sample_valid     (sample_valid),
    .collision        (collision),
    .door_fault       (door_fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=parked 1=accelerating 2=braking.
  int m_mode, m_cnt, m_speed, m_gap;
  int m_sv, m_col, m_df;

  function automatic int floor_div8(int x);
    if (x >= 0) return x / 8;
    return -((-x + 7) / 8);
  endfunction

  task automatic model();
    int tk, ns, ng, crash;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_speed = 0; m_gap = 100;
      m_sv = 0; m_col = 0; m_df = 0;
      return;
    end
    tk = (m_cnt == 3);
    if (unlock_doors && m_speed != 0) m_df = 1;
    crash = 0;
    ns = m_speed;
    if (tk) begin
      if (m_mode == 1) ns = (m_speed + 5 > 255) ? 255 : m_speed + 5;
      else if (m_mode == 2) ns = (m_speed < 10) ? 0 : m_speed - 10;
      else ns = 0;
      ng = m_gap + floor_div8(int'(leader_speed) - m_speed);
      if (ng < 0) ng = 0;
      if (ng > 127) ng = 127;
      crash = (ng == 0) && (m_speed != 0);
      if (crash) begin
        ns = 0;
        m_col = 1;
      end
      m_gap = ng;
    end
    if (m_col) m_mode = 0;
    else if (m_mode == 0) begin
      if (accelerate_car && !unlock_doors) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!accelerate_car) m_mode = 2;
    end else begin
      if (tk && ns == 0) m_mode = 0;
      else if (accelerate_car) m_mode = 1;
    end
    m_speed = ns;
    m_sv = tk;
    m_cnt = (m_cnt + 1) % 4;
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    chk("speed", car_speed, m_speed);
    chk("gap", leading_distance, m_gap);
    chk("sample_valid", sample_valid, m_sv);
    chk("collision", collision, m_col);
    chk("door_fault", door_fault, m_df);
  endtask

  typedef struct {
    logic       r;
    logic       acc;
    logic       unl;
    logic [7:0] lead;
    int         n;
    int         spd;
    int         gap;
    int         sv;
    int         col;
    int         df;
  } vec_t;

  function automatic vec_t mk(logic r, logic acc, logic unl, int lead, int n,
                              int spd, int gap, int sv, int col, int df);
    vec_t v;
    v.r = r; v.acc = acc; v.unl = unl; v.lead = 8'(lead); v.n = n;
    v.spd = spd; v.gap = gap; v.sv = sv; v.col = col; v.df = df;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    // idle after reset, first tick on 4th edge
    vt.push_back(mk(1, 0, 0,   0,  1,  0, 100, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,   0,  3,  0, 100, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,   0,  1,  0, 100, 1, 0, 0));
    vt.push_back(mk(0, 0, 0,   0,  4,  0, 100, 1, 0, 0));
    // accelerate behind a fast leader, gap saturates
    vt.push_back(mk(1, 0, 0,   0,  1,  0, 100, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 200,  4,  5, 125, 1, 0, 0));
    vt.push_back(mk(0, 1, 0, 200, 16, 25, 127, 1, 0, 0));
    // brake from 15: 5 then 0, no wrap, then parked
    vt.push_back(mk(1, 0, 0,   0,  1,  0, 100, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 200, 12, 15, 127, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 200,  4,  5, 127, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 200,  4,  0, 127, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 200,  4,  0, 127, 1, 0, 0));
    // door fault while moving, sticky
    vt.push_back(mk(1, 0, 0,   0,  1,  0, 100, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 200,  8, 10, 127, 1, 0, 0));
    vt.push_back(mk(0, 1, 1, 200,  1, 10, 127, 0, 0, 1));
    vt.push_back(mk(0, 1, 0, 200,  3, 15, 127, 1, 0, 1));
    // unlock while parked blocks start, no fault
    vt.push_back(mk(1, 0, 0,   0,  1,  0, 100, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 200,  8,  0, 127, 1, 0, 0));
    // reset mid-accel at 40, counter restarts
    vt.push_back(mk(1, 0, 0,   0,  1,  0, 100, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 200, 32, 40, 127, 1, 0, 0));
    vt.push_back(mk(1, 1, 0, 200,  1,  0, 100, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,   0,  3,  0, 100, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,   0,  1,  0, 100, 1, 0, 0));

    foreach (vt[i]) begin
      rst = vt[i].r;
      accelerate_car = vt[i].acc;
      unlock_doors = vt[i].unl;
      leader_speed = vt[i].lead;
      for (int k = 0; k < vt[i].n; k++) step();
      chk($sformatf("vec%0d_speed", i), car_speed, vt[i].spd);
      chk($sformatf("vec%0d_gap", i), leading_distance, vt[i].gap);
      chk($sformatf("vec%0d_sv", i), sample_valid, vt[i].sv);
      chk($sformatf("vec%0d_col", i), collision, vt[i].col);
      chk($sformatf("vec%0d_df", i), door_fault, vt[i].df);
    end

    // crash into a stopped leader, then stay stopped until reset
    rst = 1'b1; accelerate_car = 1'b0; unlock_doors = 1'b0; leader_speed = 8'd0;
    step();
    rst = 1'b0; accelerate_car = 1'b1;
    begin
      int guard = 0;
      while (collision !== 1'b1 && guard < 200) begin
        step();
        guard++;
      end
      chk("crash_reached", int'(collision === 1'b1), 1);
    end
    chk("crash_speed", car_speed, 0);
    chk("crash_gap", leading_distance, 0);
    for (int k = 0; k < 20; k++) step();
    chk("crash_hold_speed", car_speed, 0);
    chk("crash_hold_col", collision, 1);
    rst = 1'b1;
    step();
    chk("crash_cleared", collision, 0);

    // random run against the model
    rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) accelerate_car = ~accelerate_car;
      unlock_doors = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) leader_speed = 8'($urandom_range(0, 255));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
